// File: rtl/pc_update.sv
// Fetch program-counter update with branch redirect, stall-deferred redirect
// holding, post-redirect flush pulse and a sticky misaligned-target flag.
module pc_update #(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [63:0] br_pc,
    input  logic [63:0] br_offset,
    output logic [63:0] pc,
    output logic [63:0] pc_plus4,
    output logic        flush,
    output logic        pending,
    output logic        fault
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic [63:0] r_pend_target;
    logic        r_flush;
    logic        r_fault;

    logic [63:0] w_target;
    logic [63:0] w_target_aligned;
    logic        w_misaligned;
    logic [63:0] w_pc_plus4;

    // Wraps mod 2^64; negative offsets arrive already in two's complement.
    assign w_target         = br_pc + br_offset;
    assign w_target_aligned = {w_target[63:2], 2'b00};
    assign w_misaligned     = |w_target[1:0];
    assign w_pc_plus4       = r_pc + 64'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_pend_target <= 64'd0;
            r_flush       <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (br_taken) begin
                        if (w_misaligned) begin
                            r_fault <= 1'b1;
                        end
                        if (stall) begin
                            r_pend_target <= w_target_aligned;
                            r_state       <= PEND;
                        end else begin
                            r_pc    <= w_target_aligned;
                            r_flush <= 1'b1;
                        end
                    end else if (!stall) begin
                        r_pc <= w_pc_plus4;
                    end
                end
                PEND: begin
                    // The held redirect is older than anything EX reports now.
                    if (!stall) begin
                        r_pc    <= r_pend_target;
                        r_flush <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;
    assign flush    = r_flush;
    assign pending  = (r_state == PEND);
    assign fault    = r_fault;

endmodule

// File: tb/tb_pc_update.sv
// Directed-vector bench for pc_update; each task checks its own scenario.
module tb_pc_update;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [63:0] br_pc;
    logic [63:0] br_offset;
    logic [63:0] pc;
    logic [63:0] pc_plus4;
    logic        flush;
    logic        pending;
    logic        fault;

    int vectors;
    int miscompares;

    pc_update #(.RESET_PC(64'd0)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_pc     (br_pc),
        .br_offset (br_offset),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .flush     (flush),
        .pending   (pending),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t stall=%b br=%b br_pc=%h off=%h -> pc=%h flush=%b pend=%b fault=%b",
                 $time, stall, br_taken, br_pc, br_offset, pc, flush, pending, fault);
    endtask

    task automatic drive(input logic s, input logic b, input logic [63:0] bp, input logic [63:0] bo);
        stall     = s;
        br_taken  = b;
        br_pc     = bp;
        br_offset = bo;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 64'd0, 64'd0);
        reset = 1'b0;
        #2;
        vectors++; if (pc !== 64'd0) begin miscompares++; $display("FAIL reset_pc act=%h exp=%h", pc, 64'd0); end
        vectors++; if (pc_plus4 !== 64'd4) begin miscompares++; $display("FAIL reset_pc_plus4 act=%h exp=%h", pc_plus4, 64'd4); end
        vectors++; if ({flush, pending, fault} !== 3'b000) begin miscompares++; $display("FAIL reset_flags act=%b exp=000", {flush, pending, fault}); end
        step();
        vectors++; if (pc !== 64'd0) begin miscompares++; $display("FAIL reset_held_edge act=%h exp=%h", pc, 64'd0); end
        reset = 1'b1;
    endtask

    task automatic test_sequential();
        logic [63:0] exp_pc [3];
        exp_pc[0] = 64'h4; exp_pc[1] = 64'h8; exp_pc[2] = 64'hC;
        drive(1'b0, 1'b0, 64'd0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (pc !== exp_pc[i]) begin miscompares++; $display("FAIL seq_pc%0d act=%h exp=%h", i, pc, exp_pc[i]); end
            vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL seq_flush%0d act=%b exp=0", i, flush); end
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 64'd0, 64'd0);
        step();
        vectors++; if (pc !== 64'hC) begin miscompares++; $display("FAIL stall_hold act=%h exp=%h", pc, 64'hC); end
        vectors++; if ({flush, pending} !== 2'b00) begin miscompares++; $display("FAIL stall_flags act=%b exp=00", {flush, pending}); end
    endtask

    task automatic test_branch();
        drive(1'b0, 1'b1, 64'hF0, 64'h10);
        step();
        vectors++; if (pc !== 64'h100) begin miscompares++; $display("FAIL br_setup act=%h exp=%h", pc, 64'h100); end
        drive(1'b0, 1'b1, 64'hF8, 64'h40);
        step();
        vectors++; if (pc !== 64'h138) begin miscompares++; $display("FAIL br_target act=%h exp=%h", pc, 64'h138); end
        vectors++; if (flush !== 1'b1) begin miscompares++; $display("FAIL br_flush act=%b exp=1", flush); end
        vectors++; if (pc_plus4 !== 64'h13C) begin miscompares++; $display("FAIL br_plus4 act=%h exp=%h", pc_plus4, 64'h13C); end
        drive(1'b0, 1'b0, 64'd0, 64'd0);
        step();
        vectors++; if (pc !== 64'h13C) begin miscompares++; $display("FAIL br_next act=%h exp=%h", pc, 64'h13C); end
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL br_flush_drop act=%b exp=0", flush); end
    endtask

    task automatic test_pend();
        drive(1'b1, 1'b1, 64'h200, 64'hFFFF_FFFF_FFFF_FFF0);
        step();
        vectors++; if (pc !== 64'h13C) begin miscompares++; $display("FAIL pend_hold0 act=%h exp=%h", pc, 64'h13C); end
        vectors++; if ({pending, flush} !== 2'b10) begin miscompares++; $display("FAIL pend_enter act=%b exp=10", {pending, flush}); end
        // A younger, misaligned branch while pending must be ignored entirely.
        drive(1'b1, 1'b1, 64'h501, 64'h0);
        for (int i = 1; i < 3; i++) begin
            step();
            vectors++; if (pc !== 64'h13C) begin miscompares++; $display("FAIL pend_hold%0d act=%h exp=%h", i, pc, 64'h13C); end
            vectors++; if (pending !== 1'b1) begin miscompares++; $display("FAIL pend_level%0d act=%b exp=1", i, pending); end
        end
        drive(1'b0, 1'b1, 64'h600, 64'h0);
        step();
        vectors++; if (pc !== 64'h1F0) begin miscompares++; $display("FAIL pend_release act=%h exp=%h", pc, 64'h1F0); end
        vectors++; if ({flush, pending} !== 2'b10) begin miscompares++; $display("FAIL pend_release_flags act=%b exp=10", {flush, pending}); end
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL pend_ignored_fault act=%b exp=0", fault); end
        drive(1'b0, 1'b0, 64'd0, 64'd0);
        step();
        vectors++; if (pc !== 64'h1F4) begin miscompares++; $display("FAIL pend_after act=%h exp=%h", pc, 64'h1F4); end
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL pend_after_flush act=%b exp=0", flush); end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h4);
        step();
        vectors++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin miscompares++; $display("FAIL wrap_setup act=%h exp=%h", pc, 64'hFFFF_FFFF_FFFF_FFFC); end
        vectors++; if (pc_plus4 !== 64'h0) begin miscompares++; $display("FAIL wrap_plus4 act=%h exp=%h", pc_plus4, 64'h0); end
        drive(1'b0, 1'b0, 64'd0, 64'd0);
        step();
        vectors++; if (pc !== 64'h0) begin miscompares++; $display("FAIL wrap_seq act=%h exp=%h", pc, 64'h0); end
        drive(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20);
        step();
        vectors++; if (pc !== 64'h10) begin miscompares++; $display("FAIL wrap_target act=%h exp=%h", pc, 64'h10); end
        vectors++; if (flush !== 1'b1) begin miscompares++; $display("FAIL wrap_flush act=%b exp=1", flush); end
    endtask

    task automatic test_fault();
        drive(1'b0, 1'b1, 64'h102, 64'h8);
        step();
        vectors++; if (pc !== 64'h108) begin miscompares++; $display("FAIL fault_aligned act=%h exp=%h", pc, 64'h108); end
        vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL fault_set act=%b exp=1", fault); end
        drive(1'b0, 1'b1, 64'h200, 64'h10);
        step();
        vectors++; if (pc !== 64'h210) begin miscompares++; $display("FAIL fault_next_br act=%h exp=%h", pc, 64'h210); end
        vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL fault_sticky act=%b exp=1", fault); end
        drive(1'b1, 1'b1, 64'h301, 64'h2);
        step();
        drive(1'b0, 1'b0, 64'd0, 64'd0);
        step();
        vectors++; if (pc !== 64'h300) begin miscompares++; $display("FAIL fault_pend_aligned act=%h exp=%h", pc, 64'h300); end
        vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL fault_sticky2 act=%b exp=1", fault); end
    endtask

    task automatic test_reset_pend();
        drive(1'b1, 1'b1, 64'h400, 64'h0);
        step();
        vectors++; if (pending !== 1'b1) begin miscompares++; $display("FAIL rp_enter act=%b exp=1", pending); end
        #2;
        reset = 1'b0;
        #1;
        vectors++; if (pc !== 64'd0) begin miscompares++; $display("FAIL rp_async_pc act=%h exp=%h", pc, 64'd0); end
        vectors++; if ({flush, pending, fault} !== 3'b000) begin miscompares++; $display("FAIL rp_async_flags act=%b exp=000", {flush, pending, fault}); end
        drive(1'b0, 1'b0, 64'd0, 64'd0);
        step();
        vectors++; if (pc !== 64'd0) begin miscompares++; $display("FAIL rp_held_edge act=%h exp=%h", pc, 64'd0); end
        reset = 1'b1;
        step();
        vectors++; if (pc !== 64'h4) begin miscompares++; $display("FAIL rp_resume act=%h exp=%h", pc, 64'h4); end
        vectors++; if ({flush, pending} !== 2'b00) begin miscompares++; $display("FAIL rp_resume_flags act=%b exp=00", {flush, pending}); end
        step();
        vectors++; if (pc !== 64'h8) begin miscompares++; $display("FAIL rp_resume2 act=%h exp=%h", pc, 64'h8); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        drive(1'b0, 1'b0, 64'd0, 64'd0);
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_pend();
        test_wrap();
        test_fault();
        test_reset_pend();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_update.md
PC_UPDATE -- requirements
Module: pc_update

Interface
REQ-001 SHALL have parameter: RESET_PC, 64'd0, fetch address loaded on reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: stall  input  1  hazard stall; hold PC this cycle.
REQ-005 SHALL have port: br_taken  input  1  EX stage reports a resolved taken branch this cycle.
REQ-006 SHALL have port: br_pc  input  64  address of the branch instruction.
REQ-007 SHALL have port: br_offset  input  64  sign-extended byte offset, already shifted left by 2.
REQ-008 SHALL have port: pc  output  64  current fetch address (registered).
REQ-009 SHALL have port: pc_plus4  output  64  pc + 4, combinational, mod 2^64.
REQ-010 SHALL have port: flush  output  1  registered one-cycle pulse following each redirect load.
REQ-011 SHALL have port: pending  output  1  high while a redirect is held awaiting stall release.
REQ-012 SHALL have port: fault  output  1  sticky misaligned-target flag.

Function
REQ-013 SHALL compute target = br_pc + br_offset, 64-bit, carry discarded (wrap mod 2^64; negative offsets via two's complement).
REQ-014 SHALL implement two states: IDLE, PEND; plus a 64-bit pend_target register.
REQ-015 IDLE, stall=0, br_taken=0: pc <= pc + 4 (wraps FFFF_FFFF_FFFF_FFFC -> 0).
REQ-016 IDLE, stall=1, br_taken=0: pc holds.
REQ-017 IDLE, stall=0, br_taken=1: pc <= target; flush=1 the next cycle.
REQ-018 IDLE, stall=1, br_taken=1: pc holds; pend_target <= target; state -> PEND.
REQ-019 PEND, stall=1: pc and pend_target hold; br_taken ignored (older redirect wins).
REQ-020 PEND, stall=0: pc <= pend_target; state -> IDLE; flush=1 the next cycle; br_taken this cycle ignored.
REQ-021 pending SHALL equal (state == PEND).
REQ-022 flush SHALL be high for exactly one cycle per redirect load; never high otherwise.
REQ-023 Redirect target with [1:0] != 2'b00 SHALL set fault=1 (sticky until reset); loaded/saved address has [1:0] forced to 2'b00.
REQ-024 Fault check SHALL apply only to branches accepted in REQ-017/REQ-018; ignored branches never set fault.
REQ-025 Redirect latency: target visible on pc exactly one clock after the accepting edge.

Reset
REQ-026 reset=0 SHALL immediately (no clock) force pc=RESET_PC, state=IDLE, pend_target=0, flush=0, pending=0, fault=0.
REQ-027 Reset asserted while in PEND SHALL discard the pending redirect; first edge after release resumes from RESET_PC.
REQ-028 Reset release SHALL be synchronous-safe: no state change on the edge where reset is still 0.

Verification
REQ-029 Reset, then 3 edges with stall=0, br_taken=0 -> pc 0, 4, 8, 0xC; flush=0.
REQ-030 pc=0x100, br_taken=1, br_pc=0xF8, br_offset=0x40, stall=0 -> next pc=0x138, flush=1 one cycle, then pc=0x13C, flush=0.
REQ-031 br_taken=1, br_pc=0x200, br_offset=0xFFFF_FFFF_FFFF_FFF0, stall=1 for 3 cycles -> pending=1, pc held; on stall=0 -> pc=0x1F0, flush pulse, pending=0; second br_taken during PEND has no effect.
REQ-032 pc=0xFFFF_FFFF_FFFF_FFFC, no branch -> pc=0; br_pc=0xFFFF_FFFF_FFFF_FFF0, br_offset=0x20 -> pc=0x10.
REQ-033 br_pc=0x102, br_offset=0x8 accepted -> pc=0x108, fault=1, stays 1 through later branches until reset.
REQ-034 Enter PEND, assert reset mid-cycle -> outputs reset asynchronously; after release pc advances from RESET_PC, no flush.
